// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and the writeback request type
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req;
endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - in-order wb_req FIFO with wrap-around pointers and full/empty/count
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_req            push_data,
    input  logic             pop,
    output wb_req            pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    wb_req            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - RF write-port arbiter (A priority, buffered B) with busy scoreboard; RF_WB_BYPASS_EN adds forwarding
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [XLEN-1:0]       b_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [XLEN-1:0]       rf_wd
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                  fwd1_valid,
    output logic                  fwd2_valid,
    output logic [XLEN-1:0]       fwd_data
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    wb_req               head;
    wb_req               in_req;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;
    logic                a_eff;
    logic                b_pop;
    logic                b_push;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [SC_W-1:0]     starve_cnt;
    logic [SC_W-1:0]     starve_nxt;

    assign in_req  = '{addr: b_addr, data: b_data};
    assign b_ready = (count != CNT_W'(FIFO_DEPTH));
    // x0 destinations are accepted but never occupy a slot.
    assign b_push  = b_valid && !full && (b_addr != '0);
    assign a_eff   = a_valid && (a_addr != '0) && !rst;
    assign b_pop   = !empty && !a_eff;

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (in_req),
        .pop       (b_pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (a_eff) begin
            rf_we = 1'b1;
            rf_wa = a_addr;
            rf_wd = a_data;
        end else if (!empty) begin
            rf_we = 1'b1;
            rf_wa = head.addr;
            rf_wd = head.data;
        end
    end

    // Issue is applied after the B clear so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        if (b_pop) busy_nxt[head.addr] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (empty || b_pop)
            starve_nxt = '0;
        else if (starve_cnt != SC_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            starve_cnt <= '0;
            stall      <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            starve_cnt <= starve_nxt;
            stall      <= (starve_nxt == SC_W'(STARVE_LIMIT));
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign fwd1_valid = rf_we && (rf_wa == ra1) && (ra1 != '0);
    assign fwd2_valid = rf_we && (rf_wa == ra2) && (ra2 != '0);
    assign fwd_data   = rf_wd;
    assign busy1      = busy[ra1] && (ra1 != '0) && !fwd1_valid;
    assign busy2      = busy[ra2] && (ra2 != '0) && !fwd2_valid;
`else
    assign busy1      = busy[ra1] && (ra1 != '0);
    assign busy2      = busy[ra2] && (ra2 != '0);
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed and randomized checks of rf_wb_arbiter against a queue-based model
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        busy1;
    logic        busy2;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
`ifdef RF_WB_BYPASS_EN
    logic        fwd1_valid;
    logic        fwd2_valid;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy1       (busy1),
        .busy2       (busy2),
        .stall       (stall),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd)
`ifdef RF_WB_BYPASS_EN
        ,
        .fwd1_valid  (fwd1_valid),
        .fwd2_valid  (fwd2_valid),
        .fwd_data    (fwd_data)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Model: pending B writes in order, busy bits, consecutive losses of the head.
    wb_req       mq[$];
    logic [31:0] mbusy;
    int          mlosses;
    logic        mstall;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        mbusy   = '0;
        mlosses = 0;
        mstall  = 1'b0;
    endtask

    task automatic model_step();
        logic       a_eff;
        logic       exp_we;
        logic [4:0] exp_wa;
        logic [31:0] exp_wd;
        logic       was_empty;
        logic       was_full;
        logic       popped;
        logic       f1;
        logic       f2;
        wb_req      e;
        if (rst) begin
            model_reset();
            return;
        end
        a_eff     = a_valid && (a_addr != 5'd0);
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() >= DEPTH);
        popped    = !a_eff && !was_empty;
        exp_we    = a_eff || !was_empty;
        exp_wa    = a_eff ? a_addr : (was_empty ? 5'd0 : mq[0].addr);
        exp_wd    = a_eff ? a_data : (was_empty ? 32'd0 : mq[0].data);
        chk1("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk32("rf_wa", {27'd0, rf_wa}, {27'd0, exp_wa});
            chk32("rf_wd", rf_wd, exp_wd);
        end
        chk1("b_ready", b_ready, !was_full);
        f1 = exp_we && (exp_wa == ra1) && (ra1 != 5'd0);
        f2 = exp_we && (exp_wa == ra2) && (ra2 != 5'd0);
`ifdef RF_WB_BYPASS_EN
        chk1("fwd1_valid", fwd1_valid, f1);
        chk1("fwd2_valid", fwd2_valid, f2);
        if (exp_we) chk32("fwd_data", fwd_data, exp_wd);
        chk1("busy1", busy1, (ra1 != 5'd0) && mbusy[ra1] && !f1);
        chk1("busy2", busy2, (ra2 != 5'd0) && mbusy[ra2] && !f2);
`else
        chk1("busy1", busy1, (ra1 != 5'd0) && mbusy[ra1] && (f1 || !f1));
        chk1("busy2", busy2, (ra2 != 5'd0) && mbusy[ra2] && (f2 || !f2));
`endif
        chk1("stall", stall, mstall);
        chk1("a_valid_during_stall", a_valid && stall, 1'b0);

        if (popped) begin
            e = mq.pop_front();
            mbusy[e.addr] = 1'b0;
        end
        if (b_valid && !was_full && (b_addr != 5'd0)) begin
            e.addr = b_addr;
            e.data = b_data;
            mq.push_back(e);
        end
        if (issue_valid && (issue_rd != 5'd0)) mbusy[issue_rd] = 1'b1;
        if (was_empty || popped) mlosses = 0;
        else if (mlosses < LIMIT) mlosses++;
        mstall = (mlosses >= LIMIT);
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_valid = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0; ra1 = 5; ra2 = 0;
        model_reset();
        @(posedge clk); #1;
        chk1("reset_rf_we", rf_we, 1'b0);
        chk1("reset_b_ready", b_ready, 1'b1);
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_busy1", busy1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // A write goes straight through in the same cycle.
        a_valid = 1; a_addr = 5; a_data = 32'h1234;
        #1;
        chk1("t1_we", rf_we, 1'b1);
        chk32("t1_wa", {27'd0, rf_wa}, 32'd5);
        chk32("t1_wd", rf_wd, 32'h1234);
        chk1("t1_busy1", busy1, 1'b0);
        cyc();

        // Issue x7, B returns x7 one cycle later, write lands the cycle after.
        a_valid = 0; issue_valid = 1; issue_rd = 7; ra1 = 7;
        cyc();
        issue_valid = 0; b_valid = 1; b_addr = 7; b_data = 32'hDEAD;
        #1;
        chk1("t2_busy_set", busy1, 1'b1);
        chk1("t2_no_write_yet", rf_we, 1'b0);
        cyc();
        b_valid = 0;
        #1;
        chk1("t2_we", rf_we, 1'b1);
        chk32("t2_wa", {27'd0, rf_wa}, 32'd7);
        chk32("t2_wd", rf_wd, 32'hDEAD);
`ifdef RF_WB_BYPASS_EN
        chk1("t2_busy_fwd", busy1, 1'b0);
`else
        chk1("t2_busy_during_write", busy1, 1'b1);
`endif
        cyc();
        #1;
        chk1("t2_busy_cleared", busy1, 1'b0);

        // Starvation: A wins every cycle while two B entries wait.
        a_valid = 1; a_addr = 1; a_data = 32'h1111;
        b_valid = 1; b_addr = 3; b_data = 32'h3333;
        cyc();
        b_addr = 6; b_data = 32'h6666;
        #1;
        chk1("t3_ready_one", b_ready, 1'b1);
        cyc();
        b_valid = 0;
        #1;
        chk1("t3_ready_full", b_ready, 1'b0);
        repeat (6) cyc();
        #1;
        chk1("t3_no_stall_c8", stall, 1'b0);
        cyc();
        a_valid = 0;
        #1;
        chk1("t3_stall_c9", stall, 1'b1);
        chk32("t3_head_wa", {27'd0, rf_wa}, 32'd3);
        chk32("t3_head_wd", rf_wd, 32'h3333);
        cyc();
        #1;
        chk1("t3_stall_fall", stall, 1'b0);
        chk32("t3_second_wa", {27'd0, rf_wa}, 32'd6);
        cyc();
        #1;
        chk1("t3_drained", rf_we, 1'b0);

        // Same-cycle set and clear of x9; A write to x0 yields to B.
        b_valid = 1; b_addr = 9; b_data = 32'h9999;
        cyc();
        issue_valid = 1; issue_rd = 9; ra1 = 9; b_addr = 12; b_data = 32'hC0C0;
        #1;
        chk32("t4_b_head_wa", {27'd0, rf_wa}, 32'd9);
        cyc();
        issue_valid = 0; b_valid = 0; a_valid = 1; a_addr = 0; a_data = 32'hBAD;
        #1;
        chk1("t4_set_wins", busy1, 1'b1);
        chk32("t4_x0_yields_wa", {27'd0, rf_wa}, 32'd12);
        chk32("t4_x0_yields_wd", rf_wd, 32'hC0C0);
        cyc();
        a_valid = 0;
        #1;
        chk1("t4_idle", rf_we, 1'b0);

        // Reset mid-run with FIFO full and busy set.
        a_valid = 1; a_addr = 2; issue_valid = 1; issue_rd = 13; ra1 = 13;
        b_valid = 1; b_addr = 10; b_data = 32'hA0A0;
        cyc();
        issue_valid = 0; b_addr = 11; b_data = 32'hB0B0;
        cyc();
        b_valid = 0;
        #1;
        chk1("t5_full", b_ready, 1'b0);
        chk1("t5_busy", busy1, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("t5_rst_we", rf_we, 1'b0);
        chk1("t5_rst_ready", b_ready, 1'b1);
        chk1("t5_rst_busy", busy1, 1'b0);
        chk1("t5_rst_stall", stall, 1'b0);
        a_valid = 0;
        cyc();
        rst = 1'b0;
        #1;
        chk1("t5_no_stale", rf_we, 1'b0);
        cyc();

`ifdef RF_WB_BYPASS_EN
        issue_valid = 1; issue_rd = 4; b_valid = 1; b_addr = 4; b_data = 32'h55; ra2 = 4;
        cyc();
        issue_valid = 0; b_valid = 0;
        #1;
        chk1("t6_fwd2", fwd2_valid, 1'b1);
        chk32("t6_fwd_data", fwd_data, 32'h55);
        chk1("t6_busy2", busy2, 1'b0);
        chk1("t6_fwd1", fwd1_valid, 1'b0);
        cyc();
`endif

        // Randomized traffic with alternating A-heavy and A-light phases.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rd;
            rst     = (i == 1500);
            a_valid = !mstall && ($urandom_range(0, 99) < ((((i / 200) % 2) == 0) ? 95 : 30));
            a_addr  = 5'($urandom_range(0, 31));
            a_data  = $urandom;
            b_valid = ($urandom_range(0, 99) < 50);
            b_addr  = 5'($urandom_range(0, 31));
            b_data  = $urandom;
            rd      = 5'($urandom_range(0, 31));
            issue_rd    = rd;
            issue_valid = ($urandom_range(0, 99) < 30) && !mbusy[rd];
            ra1     = 5'($urandom_range(0, 31));
            ra2     = 5'($urandom_range(0, 31));
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Source A: the in-order pipeline writeback stage. It has fixed priority and no backpressure.
  - Source B: long-latency units (load/MMIO/divider). Writes are buffered in a small FIFO.
- Holds a 32-entry busy scoreboard so decode can stall on registers with an outstanding B write.
- Sits between the WB stage, the long-latency units and the register file's we/wa/wd inputs.

Parameters:
- FIFO_DEPTH, 2: number of B-write entries buffered; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive cycles the B head may lose arbitration before the pipeline is stalled.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- a_valid  in  1  pipeline writeback this cycle.
- a_addr  in  5  pipeline destination register.
- a_data  in  32  pipeline write data.
- b_valid  in  1  long-latency result offered.
- b_ready  out  1  FIFO can accept; transfer when b_valid&&b_ready.
- b_addr  in  5  long-latency destination register.
- b_data  in  32  long-latency write data.
- issue_valid  in  1  decode issued a long-latency op this cycle.
- issue_rd  in  5  destination of that op.
- ra1, ra2  in  5 each  decode source registers to check.
- busy1, busy2  out  1 each  source has a pending B write.
- stall  out  1  pipeline must hold; it must drive a_valid=0 while high.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - FIFO emptied and contents discarded.
  - Busy vector cleared.
  - Starvation counter = 0; stall = 0.
  - rf_we = 0; b_ready = 1 once FIFO empty.
- Write-port mux (combinational, zero latency):
  - A effective when a_valid && a_addr != 0. It drives rf_we=1, rf_wa=a_addr, rf_wd=a_data.
  - Otherwise, if the FIFO is non-empty, pop the head and drive it onto rf_*.
  - Otherwise rf_we = 0.
  - A write to x0 is a no-write; the port goes to B that cycle.
- B acceptance:
  - b_ready = !full, from the registered count.
  - Accepted b_addr == 0 is consumed but not enqueued.
  - Minimum B latency: accepted at cycle t, earliest rf write at t+1.
  - FIFO is in order, with wrap-around pointers.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy[issue_rd].
  - A B-sourced rf write clears busy[rf_wa].
  - Same register set and cleared in one cycle: set wins.
  - busy1/busy2 = busy[ra1]/busy[ra2], combinational from the registered vector; x0 always reads 0.
  - Decode must not issue a second long-latency op to a busy register.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and the head is not popped.
  - It clears on any pop, or when the FIFO becomes empty.
  - stall is registered. It asserts the cycle after the counter reaches STARVE_LIMIT.
  - stall stays high until the head pops, then deasserts on the next edge.
  - a_valid=1 while stall is high is a protocol violation: A still wins, and the bench asserts on it.
- Other simultaneous cases:
  - A write and B write to the same register in one cycle is impossible (single port).
  - Ordering between A and B to the same register is decode's responsibility via busy.

Optional Feature:
- RF_WB_BYPASS_EN defined:
  - Adds outputs fwd1_valid, fwd2_valid (1 bit each) and fwd_data (32).
  - fwdN_valid = rf_we && rf_wa == raN && raN != 0, combinational.
  - fwd_data = rf_wd.
  - busyN is forced 0 when fwdN_valid, so decode consumes the value being written this cycle instead of stalling.
- Undefined: these ports are absent, and busy clears only on the edge after the write.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - wb_req typedef {addr, data}.
- Sub-module rf_wb_fifo:
  - Parameterised synchronous FIFO of wb_req, with full/empty/count.
  - Reused elsewhere for MMIO response buffering.
- Scoreboard, mux and starvation logic stay in rf_wb_arbiter.

Test Plan:
1. Reset, then A writes x5=0x1234 -> rf_we=1, wa=5, wd=0x1234 same cycle; B idle; busy all 0.
2. issue x7, B delivers x7=0xDEAD at t, A idle -> rf write x7 at t+1; busy1(ra1=7) 1 until edge after write, then 0.
3. A valid every cycle, two B pushes -> b_ready drops after 2nd push; stall rises on the cycle after 8 losing cycles. With a_valid held 0, head x3 writes and stall falls next edge; second entry drains after.
4. Simultaneous issue_valid x9 and B write-out of x9 -> busy[9]=1 afterwards; A write to x0 with B head pending -> B head written that cycle.
5. Assert rst mid-run with FIFO full and busy nonzero -> all outputs to reset values immediately; no stale B write after release.
6. With RF_WB_BYPASS_EN: B writes x4=0x55 while ra2=4 -> fwd2_valid=1, fwd_data=0x55, busy2=0.
